// File: rtl/planificador_enlace_if.sv
// Requester bus for planificador_enlace.
// Carries two independent requesters, each a valid/data/ready handshake.
//   reqN_valid : requester N has a 10-bit word pending
//   reqN_data  : the pending word, held stable until it is accepted
//   reqN_ready : scheduler accepts the word on this clock edge
// master : requester side (drives valid/data, observes ready)
// slave  : scheduler side (observes valid/data, drives ready)
interface planificador_enlace_if;
  logic       req0_valid;
  logic [9:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [9:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/planificador_enlace.sv
// Link scheduler feeding a 10-bit parallel-to-serial emitter.
// Trains the far end with comma words, waits for receiver alignment, then
// round-robins two requesters into word slots of 10 clocks each, forcing a
// comma slot every SYNC_PERIOD data/idle slots.
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst        : synchronous active-high reset (overrides i_enb)
//   i_enb        : enable; low freezes all state
//   i_rx_aligned : receiver reports word alignment
//   i_req        : requester bus (slave side), ready is combinational
//   o_word_out   : registered word for the emitter
//   o_word_load  : one-cycle pulse in the cycle after each slot boundary
//   o_estado     : 00 TRAIN, 01 WAIT_ALIGN, 10 ACTIVE
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_TRAIN   | send COMMA for TRAIN_WORDS slots
// ST_WAIT    | send COMMA until rx_aligned is seen at a slot boundary
// ST_ACTIVE  | serve requesters / IDLE, periodic forced COMMA
module planificador_enlace #(
  parameter int          TRAIN_WORDS = 16,
  parameter int          SYNC_PERIOD = 64,
  parameter logic [9:0]  COMMA       = 10'b0011111010,
  parameter logic [9:0]  IDLE        = 10'b1010010101
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enb,
  input  logic                  i_rx_aligned,
  planificador_enlace_if.slave  i_req,
  output logic [9:0]            o_word_out,
  output logic                  o_word_load,
  output logic [1:0]            o_estado
);

  localparam int TW_W = $clog2(TRAIN_WORDS + 1);
  localparam int SP_W = $clog2(SYNC_PERIOD + 1);
  localparam logic [TW_W-1:0] TRAIN_LAST = TW_W'(TRAIN_WORDS - 1);
  localparam logic [SP_W-1:0] SYNC_TOP   = SP_W'(SYNC_PERIOD);
  localparam logic [3:0]      SLOT_LAST  = 4'd9;

  typedef enum logic [1:0] {
    ST_TRAIN  = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  state_t          r_state;
  logic [3:0]      r_slot;
  logic [TW_W-1:0] r_train;
  logic [SP_W-1:0] r_sync;
  logic [9:0]      r_word;
  logic            r_load;
  logic            r_last;   // 1: requester 1 was granted last

  logic w_bnd;
  logic w_force;
  logic w_serve;
  logic w_sel0;
  logic w_sel1;

  // Slot boundary: the enabled edge that closes slot position 9.
  assign w_bnd   = i_enb && !i_rst && (r_slot == SLOT_LAST);
  assign w_force = (r_sync == SYNC_TOP);
  // A drop of rx_aligned at the boundary wins over any pending request.
  assign w_serve = w_bnd && (r_state == ST_ACTIVE) && i_rx_aligned && !w_force;

  // Round robin: on a tie, the requester not granted last wins.
  assign w_sel0 = i_req.req0_valid && (!i_req.req1_valid || r_last);
  assign w_sel1 = i_req.req1_valid && (!i_req.req0_valid || !r_last);

  assign i_req.req0_ready = w_serve && w_sel0;
  assign i_req.req1_ready = w_serve && w_sel1;

  assign o_word_out  = r_word;
  // The pulse flag survives a freeze; gating keeps word_load low while enb=0.
  assign o_word_load = r_load && i_enb;
  assign o_estado    = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_TRAIN;
      r_slot  <= '0;
      r_train <= '0;
      r_sync  <= '0;
      r_word  <= COMMA;
      r_load  <= 1'b0;
      r_last  <= 1'b1;
    end else if (i_enb) begin
      r_load <= (r_slot == SLOT_LAST);
      if (r_slot == SLOT_LAST) begin
        r_slot <= '0;
        case (r_state)
          ST_TRAIN: begin
            r_word <= COMMA;
            if (r_train == TRAIN_LAST) begin
              r_train <= '0;
              r_state <= ST_WAIT;
            end else begin
              r_train <= r_train + 1'b1;
            end
          end
          ST_WAIT: begin
            r_word <= COMMA;
            if (i_rx_aligned) begin
              r_state <= ST_ACTIVE;
              r_sync  <= '0;
            end
          end
          ST_ACTIVE: begin
            if (!i_rx_aligned) begin
              r_state <= ST_TRAIN;
              r_train <= '0;
              r_sync  <= '0;
              r_word  <= COMMA;
            end else if (w_force) begin
              r_word <= COMMA;
              r_sync <= '0;
            end else begin
              if (w_sel0 || w_sel1) begin
                r_word <= w_sel0 ? i_req.req0_data : i_req.req1_data;
                r_last <= w_sel1;
              end else begin
                r_word <= IDLE;
              end
              r_sync <= r_sync + 1'b1;
            end
          end
          default: begin
            r_state <= ST_TRAIN;
            r_train <= '0;
            r_sync  <= '0;
            r_word  <= COMMA;
          end
        endcase
      end else begin
        r_slot <= r_slot + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_planificador_enlace.sv
module tb_planificador_enlace;
  localparam int         TW    = 16;
  localparam int         SP    = 64;
  localparam logic [9:0] COMMA = 10'b0011111010;
  localparam logic [9:0] IDLE  = 10'b1010010101;
  localparam logic [9:0] D0    = 10'h0F0;
  localparam logic [9:0] D1    = 10'h30F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enb = 1'b1;
  logic rx  = 1'b1;
  always #5 clk = ~clk;

  planificador_enlace_if bus ();
  logic [9:0] word_out;
  logic       word_load;
  logic [1:0] estado;

  planificador_enlace #(.TRAIN_WORDS(TW), .SYNC_PERIOD(SP), .COMMA(COMMA), .IDLE(IDLE)) dut (
    .i_clk(clk), .i_rst(rst), .i_enb(enb), .i_rx_aligned(rx),
    .i_req(bus), .o_word_out(word_out), .o_word_load(word_load), .o_estado(estado)
  );

  int checks = 0;
  int failures = 0;

  // Reference: slot position, phase (0 train, 1 wait, 2 active), slots spent
  // training, data/idle slots since the last comma, and the round-robin owner.
  int         m_slot, m_state, m_train, m_sync, m_last;
  logic [9:0] m_word;
  bit         m_loadflag;
  bit         x0, x1;
  int         mode;       // 0 none, 1 fixed pair, 2 random both, 3 req0 only
  bit         rand_enb, rand_rx, rand_rst;

  function automatic int m_grant();
    if (bus.req0_valid && bus.req1_valid) return (m_last == 1) ? 0 : 1;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(int n);
    return !rst && enb && m_slot == 9 && m_state == 2 && rx && m_sync != SP && m_grant() == n;
  endfunction

  task automatic model_edge();
    int g;
    x0 = m_ready(0) && bus.req0_valid;
    x1 = m_ready(1) && bus.req1_valid;
    if (rst) begin
      m_slot = 0; m_state = 0; m_train = 0; m_sync = 0; m_last = 1;
      m_word = COMMA; m_loadflag = 0;
    end else if (enb) begin
      m_loadflag = (m_slot == 9);
      if (m_slot == 9) begin
        m_slot = 0;
        if (m_state == 0) begin
          m_word = COMMA;
          m_train++;
          if (m_train == TW) begin m_state = 1; m_train = 0; end
        end else if (m_state == 1) begin
          m_word = COMMA;
          if (rx) begin m_state = 2; m_sync = 0; end
        end else if (!rx) begin
          m_state = 0; m_train = 0; m_sync = 0; m_word = COMMA;
        end else if (m_sync == SP) begin
          m_word = COMMA; m_sync = 0;
        end else begin
          g = m_grant();
          if (g == 0) m_word = bus.req0_data;
          else if (g == 1) m_word = bus.req1_data;
          else m_word = IDLE;
          if (g >= 0) m_last = g;
          m_sync++;
        end
      end else begin
        m_slot++;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("word_out", {22'd0, word_out}, {22'd0, m_word});
    check("word_load", {31'd0, word_load}, {31'd0, m_loadflag && enb});
    check("estado", {30'd0, estado}, 32'(m_state));
    check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, m_ready(0)});
    check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, m_ready(1)});
    check("one_ready", {31'd0, bus.req0_ready && bus.req1_ready}, 32'd0);
  endtask

  task automatic drive();
    if (rand_enb) enb = ($urandom_range(0, 7) != 0);
    if (rand_rst) rst = ($urandom_range(0, 499) == 0);
    if (rand_rx) begin
      if (rx) rx = ($urandom_range(0, 299) != 0);
      else    rx = ($urandom_range(0, 29) == 0);
    end
    case (mode)
      0: begin bus.req0_valid = 0; bus.req1_valid = 0; end
      1: begin
        bus.req0_valid = 1; bus.req0_data = D0;
        bus.req1_valid = 1; bus.req1_data = D1;
      end
      2: begin
        if (!bus.req0_valid || x0) begin
          bus.req0_valid = ($urandom_range(0, 2) != 0); bus.req0_data = 10'($urandom);
        end
        if (!bus.req1_valid || x1) begin
          bus.req1_valid = ($urandom_range(0, 2) != 0); bus.req1_data = 10'($urandom);
        end
      end
      default: begin
        if (!bus.req0_valid || x0) begin bus.req0_valid = 1; bus.req0_data = 10'($urandom); end
        bus.req1_valid = 0;
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    drive();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int seen_r0, seen_load, k;
    bit done;
    bus.req0_valid = 0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_data = '0;
    rand_enb = 0; rand_rx = 0; rand_rst = 0; x0 = 0; x1 = 0;
    m_slot = 0; m_state = 0; m_train = 0; m_sync = 0; m_last = 1; m_word = COMMA; m_loadflag = 0;
    mode = 1;

    // Reset, training, one WAIT slot, then alternating grants.
    run(2);
    rst = 0;
    check("rst_estado", {30'd0, estado}, 32'd0);
    check("rst_word", {22'd0, word_out}, {22'd0, COMMA});
    check("rst_load", {31'd0, word_load}, 32'd0);
    run(160);
    check("train_to_wait", {30'd0, estado}, 32'd1);
    run(10);
    check("wait_to_active", {30'd0, estado}, 32'd2);
    check("wait_word", {22'd0, word_out}, {22'd0, COMMA});
    run(10);
    check("rr_first", {22'd0, word_out}, {22'd0, D0});
    check("rr_first_load", {31'd0, word_load}, 32'd1);
    run(10);
    check("rr_second", {22'd0, word_out}, {22'd0, D1});
    run(10);
    check("rr_third", {22'd0, word_out}, {22'd0, D0});
    run(200);

    // Idle traffic across a forced comma slot.
    mode = 0;
    run(700);

    // rx_aligned drop in ACTIVE with requester 0 pending.
    mode = 3;
    run(13);
    rx = 0;
    seen_r0 = 0;
    done = 0;
    for (k = 0; k < 20 && !done; k++) begin
      cycle();
      if (bus.req0_ready) seen_r0++;
      if (estado != 2'd2) done = 1;
    end
    check("drop_estado", {30'd0, estado}, 32'd0);
    check("drop_word", {22'd0, word_out}, {22'd0, COMMA});
    check("drop_no_ready", 32'(seen_r0), 32'd0);

    // Alignment held low: stays in WAIT_ALIGN.
    run(400);
    check("wait_hold", {30'd0, estado}, 32'd1);
    check("wait_hold_word", {22'd0, word_out}, {22'd0, COMMA});
    rx = 1;
    run(10);
    check("wait_release", {30'd0, estado}, 32'd2);

    // Freeze mid-slot for 25 clocks.
    mode = 1;
    done = 0;
    for (k = 0; k < 12 && !done; k++) begin
      cycle();
      if (m_slot == 4) done = 1;
    end
    check("freeze_reach_slot", {31'd0, done}, 32'd1);
    enb = 0;
    seen_load = 0;
    for (k = 0; k < 25; k++) begin
      cycle();
      if (word_load) seen_load++;
    end
    check("freeze_no_load", 32'(seen_load), 32'd0);
    enb = 1;
    run(5);
    check("resume_no_load_yet", {31'd0, word_load}, 32'd0);
    run(1);
    check("resume_load", {31'd0, word_load}, 32'd1);

    // Random traffic with enable gaps.
    mode = 2;
    rand_enb = 1;
    run(2000);

    // Random traffic with alignment loss and occasional reset.
    rand_rx = 1;
    rand_rst = 1;
    run(3000);
    rand_enb = 0; rand_rx = 0; rand_rst = 0;
    rst = 0; enb = 1; rx = 1;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/planificador_enlace.md
PLANIFICADOR_ENLACE -- requirements
Module: planificador_enlace

Interface
REQ-001 Parameter TRAIN_WORDS, default 16, meaning: comma words sent in TRAIN before checking alignment.
REQ-002 Parameter SYNC_PERIOD, default 64, meaning: in ACTIVE, one comma slot is forced after every SYNC_PERIOD data/idle slots.
REQ-003 Parameter COMMA, default 10'b0011111010, meaning: alignment word.
REQ-004 Parameter IDLE, default 10'b1010010101, meaning: filler word when no requester is served.
REQ-005 clk  in  1  system clock; single clock domain, rising edge only.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enb  in  1  enable; low freezes all state.
REQ-008 req0_valid  in  1  requester 0 has a word.
REQ-009 req0_data  in  10  requester 0 word.
REQ-010 req0_ready  out  1  requester 0 word accepted this cycle.
REQ-011 req1_valid, req1_data, req1_ready  in/in/out  1/10/1  same meanings as REQ-008..REQ-010 for requester 1.
REQ-012 rx_aligned  in  1  receiver reports word alignment.
REQ-013 word_out  out  10  registered word presented to the parallel-serial emitter entradas.
REQ-014 word_load  out  1  one-cycle pulse: word_out changed this slot.
REQ-015 estado  out  2  current state: 00 TRAIN, 01 WAIT_ALIGN, 10 ACTIVE.

Function
REQ-016 Slot counter 0..9 SHALL advance once per clk while enb=1, wrap 9->0; one slot = 10 clk.
REQ-017 Slot boundary = cycle with slot counter 9 and enb=1; word_out, state and slot-based counters SHALL update only on that edge.
REQ-018 word_load SHALL be 1 for exactly the cycle after each slot boundary (slot counter 0), else 0.
REQ-019 TRAIN: word_out=COMMA each slot; count slots; after TRAIN_WORDS slots -> WAIT_ALIGN.
REQ-020 WAIT_ALIGN: word_out=COMMA; at a slot boundary with rx_aligned=1 -> ACTIVE; otherwise stay, with no timeout.
REQ-021 ACTIVE: at each slot boundary, if sync counter = SYNC_PERIOD, load COMMA, clear sync counter, grant nobody; else load granted data or IDLE and increment sync counter.
REQ-022 ACTIVE with rx_aligned=0 sampled at a slot boundary SHALL go to TRAIN, clear train/sync counters, and load COMMA at that boundary.
REQ-023 Arbitration round-robin: both valid -> grant requester not granted last; one valid -> that one; none -> IDLE, last-grant unchanged.
REQ-024 reqN_ready SHALL be combinational: 1 only at a slot boundary, in ACTIVE, rx_aligned=1, no forced comma, and requester N selected per REQ-023; transfer = valid & ready, data captured into word_out at that edge.
REQ-025 At most one ready high per cycle; ready never high outside slot boundary; a requester holds valid/data stable until its transfer.
REQ-026 enb=0: slot counter, state, counters, word_out and last-grant hold; word_load=0; both ready=0.
REQ-027 Simultaneous rx_aligned drop and pending requests at a boundary: drop wins, no ready asserted.

Reset
REQ-028 rst=1 at a rising edge SHALL set state TRAIN, slot/train/sync counters 0, word_out=COMMA, word_load=0, last-grant=1 (so requester 0 wins first tie); ready outputs 0 while rst=1.
REQ-029 rst SHALL override enb; reset mid-slot or mid-ACTIVE discards the pending slot with no transfer.

Verification
REQ-030 Reset, enb=1, rx_aligned=1: 16 COMMA slots (160 clk), then ACTIVE; word_load pulses every 10 clk; estado 00->01->10 with one slot in WAIT_ALIGN.
REQ-031 rx_aligned held 0: state stays WAIT_ALIGN indefinitely, word_out=COMMA, readies 0; raise rx_aligned -> ACTIVE at next boundary.
REQ-032 ACTIVE, both valid, data 10'h0F0 / 10'h30F: grants alternate 0,1,0,1; word_out sequence 0F0,30F,...; no ready outside boundary.
REQ-033 ACTIVE, no valid: word_out=IDLE; after 64 slots one COMMA slot with both readies 0, then resumes.
REQ-034 Drop rx_aligned in ACTIVE with req0_valid=1: next boundary loads COMMA, estado=00, req0_ready stays 0.
REQ-035 enb low for 25 clk mid-slot: all outputs and counters frozen, word_load 0; slot resumes at frozen count after enb=1.
